cfg_reg_file: RTL and testbench
===============================

# cfg_reg_file

Parametrised configuration register file for the multi-clock communication system, sitting in the reference clock domain between the system controller and the ALU, UART and clock-divider configuration inputs. It generalises depth, width and the number of exported registers, and adds:

- per-register write protection,
- simultaneous read and write,
- out-of-range address detection,
- a write-update strobe so downstream blocks can re-latch configuration.

## Interface

Parameters:
- DATA_WIDTH, 8, register width in bits.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of implemented registers; must satisfy 4 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- OUT_REGS, 4, number of low registers exported on REG_OUT; must satisfy 1 ≤ OUT_REGS ≤ DEPTH.
- RST_INIT_LO, {8'h08, 8'h21, 8'h00, 8'h00}, 4*DATA_WIDTH reset image of registers 3..0. Register 0 is in the LSBs; reg2 = UART config, reg3 = divider ratio. Registers 4 and above reset to 0.
- RO_MASK, 0, DEPTH-bit mask; bit i set makes register i read-only.

Ports:
- CLK, in, 1, the block's single clock.
- RST, in, 1, asynchronous active-low reset.
- address, in, ADDR_WIDTH, register index for the current access.
- WrEn, in, 1, write request, sampled on rising CLK.
- RdEn, in, 1, read request, sampled on rising CLK.
- WrData, in, DATA_WIDTH, write data.
- RdData, out, DATA_WIDTH, registered read data.
- RdData_valid, out, 1, one-cycle strobe qualifying RdData.
- Access_err, out, 1, one-cycle strobe for a rejected access.
- Upd_strobe, out, 1, one-cycle strobe after a register's stored value changes.
- Upd_index, out, ADDR_WIDTH, index of the changed register; valid while Upd_strobe is high.
- REG_OUT, out, OUT_REGS*DATA_WIDTH, live contents of registers 0..OUT_REGS-1, register 0 in the LSBs.

## Operation

- Reset (RST low), asynchronous:
  - registers take the RST_INIT_LO image, others 0;
  - RdData = 0, RdData_valid = 0, Access_err = 0, Upd_strobe = 0, Upd_index = 0.
- Address legality: an address is out of range when address ≥ DEPTH.
- Write (WrEn = 1):
  - If the address is in range and RO_MASK[address] = 0, store WrData.
  - If the stored value changed, set Upd_strobe = 1 and Upd_index = address on the next edge.
  - Writing an identical value produces no Upd_strobe.
- Write rejected (out of range or read-only):
  - storage is unchanged;
  - Access_err = 1 for one cycle;
  - no Upd_strobe.
- Read (RdEn = 1):
  - In range: RdData = register contents, RdData_valid = 1.
  - Out of range: RdData = 0, RdData_valid = 1, Access_err = 1.
- RdData holds its last value while RdData_valid = 0.
- WrEn and RdEn both high:
  - both operations are performed in the same cycle;
  - read data follows the Configuration section (old contents, or bypassed WrData).
- Access_err is the OR of the read and write error conditions; it is high for one cycle per offending access cycle.
- REG_OUT reflects stored contents combinationally from the register outputs, with no extra delay beyond the storing edge.

## Timing

- Read latency is 1 cycle: request on edge N, RdData and RdData_valid visible after edge N, held high for exactly one cycle per request.
- Back-to-back reads produce RdData_valid continuously high, with new data each cycle.
- Write takes effect at edge N:
  - REG_OUT updates after edge N;
  - Upd_strobe and Upd_index are high for the cycle following edge N.
- Reset asserted mid-access aborts it: the write is not stored, and no strobes appear after reset is released.
- All outputs are registers; there is no combinational path from inputs to outputs except REG_OUT from storage.

## Configuration

- Macro: CFG_REG_FILE_WR_BYPASS_EN.
- Defined: a simultaneous WrEn and RdEn to the same legal, writable address returns WrData on RdData (write-through).
- Undefined: the same access returns the pre-write contents (read-before-write).
- In both modes:
  - a simultaneous read of a read-only or out-of-range address returns stored contents (or 0 if out of range);
  - Upd_strobe behaviour is unchanged.

## Test plan

- Reset release, defaults (DATA_WIDTH = 8) → REG_OUT = 32'h0821_0000; RdData = 0; all strobes low; reading addr 3 gives RdData = 8'h08 with RdData_valid for one cycle.
- Write 8'hA5 to addr 0, then write 8'hA5 to addr 0 again → first write gives REG_OUT[7:0] = 8'hA5 and Upd_strobe with Upd_index = 0; second write gives no Upd_strobe.
- RO_MASK = 16'h0008, write 8'h10 to addr 3 → REG_OUT[31:24] stays 8'h08; Access_err pulses; no Upd_strobe.
- DEPTH = 12, read then write at addr 13 → read gives RdData = 0, RdData_valid = 1, Access_err = 1; write leaves all registers unchanged and pulses Access_err.
- Addr 1 holds 8'h33; WrEn and RdEn together with WrData = 8'h5C → RdData = 8'h33 without the macro, 8'h5C with it; the register becomes 8'h5C in both builds.
- WrEn to addr 2 with RST pulled low in the same cycle → REG_OUT[23:16] = 8'h21; no Upd_strobe after release; reads 4 back-to-back give RdData_valid high for 4 consecutive cycles.

Source files
------------

// File: rtl/cfg_reg_file.sv
// cfg_reg_file: parametrised configuration register file with write protection,
// out-of-range detection, simultaneous read/write and a change-update strobe.
//   CLK, RST (async active-low)        clock and reset
//   address, WrEn, RdEn, WrData        access request, sampled on rising CLK
//   RdData, RdData_valid               registered read data and its one-cycle qualifier
//   Access_err                         one-cycle strobe for a rejected read or write
//   Upd_strobe, Upd_index              one-cycle strobe and index after a stored value changes
//   REG_OUT                            live contents of registers 0..OUT_REGS-1, reg 0 in LSBs
// Optional feature: define CFG_REG_FILE_WR_BYPASS_EN for write-through on a
// simultaneous read and write of the same writable register.
module cfg_reg_file #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned OUT_REGS = 4,
  parameter logic [4*DATA_WIDTH-1:0] RST_INIT_LO = (4*DATA_WIDTH)'(32'h0821_0000),
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           WrEn,
  input  logic                           RdEn,
  input  logic [DATA_WIDTH-1:0]          WrData,
  output logic [DATA_WIDTH-1:0]          RdData,
  output logic                           RdData_valid,
  output logic                           Access_err,
  output logic                           Upd_strobe,
  output logic [ADDR_WIDTH-1:0]          Upd_index,
  output logic [OUT_REGS*DATA_WIDTH-1:0] REG_OUT
);
  localparam int unsigned W = DEPTH * DATA_WIDTH;
  localparam logic [W-1:0] INIT_IMG = W'(RST_INIT_LO);
`ifdef CFG_REG_FILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [W-1:0]            regs_q, regs_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d, cur;
  logic [ADDR_WIDTH-1:0]   upd_idx_q, upd_idx_d;
  logic                    rd_valid_q, err_q, err_d, upd_q, upd_d;
  logic                    hit, ro, wr_ok;
  // Storage is a flat vector so the reset image and REG_OUT are plain slices;
  // the address decode loop also yields range legality without index-width games.
  always_comb begin
    hit = 1'b0;
    ro = 1'b0;
    cur = '0;
    regs_d = regs_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (address == ADDR_WIDTH'(k)) begin
        hit = 1'b1;
        ro = RO_MASK[k];
        cur = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    wr_ok = WrEn && hit && !ro;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_ok && address == ADDR_WIDTH'(k)) regs_d[k*DATA_WIDTH +: DATA_WIDTH] = WrData;
    end
    upd_d = wr_ok && (cur != WrData);
    upd_idx_d = upd_d ? address : upd_idx_q;
    err_d = (WrEn && !wr_ok) || (RdEn && !hit);
    rd_data_d = !RdEn ? rd_data_q : !hit ? '0 : (BYPASS && wr_ok) ? WrData : cur;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      regs_q <= INIT_IMG;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= RdEn;
      err_q <= err_d;
      upd_q <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end
  assign RdData = rd_data_q;
  assign RdData_valid = rd_valid_q;
  assign Access_err = err_q;
  assign Upd_strobe = upd_q;
  assign Upd_index = upd_idx_q;
  assign REG_OUT = regs_q[OUT_REGS*DATA_WIDTH-1:0];
endmodule

// File: tb/tb_cfg_reg_file.sv
// tb_cfg_reg_file: directed and random checks of cfg_reg_file (DEPTH=12, reg 3 read-only)
module tb_cfg_reg_file;
  localparam int DEPTH = 12;
`ifdef CFG_REG_FILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       u;
    logic [3:0] ui;
    logic [31:0] ro;
  } exp_t;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  address = '0;
  logic        WrEn = 1'b0;
  logic        RdEn = 1'b0;
  logic [7:0]  WrData = '0;
  logic [7:0]  RdData;
  logic        RdData_valid;
  logic        Access_err;
  logic        Upd_strobe;
  logic [3:0]  Upd_index;
  logic [31:0] REG_OUT;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [7:0]  mem [DEPTH];
  logic [7:0]  last_d;
  cfg_reg_file #(.DEPTH(DEPTH), .RO_MASK(12'h008)) dut (
    .CLK(CLK), .RST(RST), .address(address), .WrEn(WrEn), .RdEn(RdEn),
    .WrData(WrData), .RdData(RdData), .RdData_valid(RdData_valid),
    .Access_err(Access_err), .Upd_strobe(Upd_strobe), .Upd_index(Upd_index),
    .REG_OUT(REG_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mem[2] = 8'h21;
    mem[3] = 8'h08;
    last_d = 8'h00;
  endtask
  // Drive one access, push its expected outcome, then pop and compare after the edge.
  task automatic step(input logic we, input logic re, input logic [3:0] a, input logic [7:0] wd);
    exp_t e;
    logic hit, wok;
    logic [7:0] cur;
    @(negedge CLK);
    WrEn = we;
    RdEn = re;
    address = a;
    WrData = wd;
    hit = (int'(a) < DEPTH);
    wok = we && hit && (a != 4'd3);
    cur = hit ? mem[a] : 8'h00;
    e.v = re;
    e.d = re ? (hit ? ((BYPASS && wok) ? wd : cur) : 8'h00) : last_d;
    last_d = e.d;
    e.e = (we && !wok) || (re && !hit);
    e.u = wok && (cur != wd);
    e.ui = a;
    if (wok) mem[a] = wd;
    e.ro = {mem[3], mem[2], mem[1], mem[0]};
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("valid@%0d", a), 32'(RdData_valid), 32'(e.v));
    chk($sformatf("rdata@%0d", a), 32'(RdData), 32'(e.d));
    chk($sformatf("err@%0d", a), 32'(Access_err), 32'(e.e));
    chk($sformatf("upd@%0d", a), 32'(Upd_strobe), 32'(e.u));
    if (e.u) chk($sformatf("upd_idx@%0d", a), 32'(Upd_index), 32'(e.ui));
    chk($sformatf("reg_out@%0d", a), REG_OUT, e.ro);
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_reg_out", REG_OUT, 32'h0821_0000);
    chk("rst_rdata", 32'(RdData), 32'h0);
    chk("rst_strobes", {29'h0, RdData_valid, Access_err, Upd_strobe}, 32'h0);
    chk("rst_upd_idx", 32'(Upd_index), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    step(1'b0, 1'b1, 4'd3, 8'h00);
    chk("read3_const", 32'(RdData), 32'h08);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    chk("valid_one_cycle", 32'(RdData_valid), 32'h0);
    step(1'b1, 1'b0, 4'd0, 8'hA5);
    chk("wr_a5_reg0", 32'(REG_OUT[7:0]), 32'hA5);
    step(1'b1, 1'b0, 4'd0, 8'hA5);
    chk("same_val_no_upd", 32'(Upd_strobe), 32'h0);
    step(1'b1, 1'b0, 4'd3, 8'h10);
    chk("ro_reg3_kept", 32'(REG_OUT[31:24]), 32'h08);
    step(1'b0, 1'b1, 4'd13, 8'h00);
    step(1'b1, 1'b0, 4'd13, 8'hFF);
    step(1'b1, 1'b0, 4'd1, 8'h33);
    step(1'b1, 1'b1, 4'd1, 8'h5C);
    chk("rw_same_rdata", 32'(RdData), BYPASS ? 32'h5C : 32'h33);
    step(1'b0, 1'b1, 4'd1, 8'h00);
    chk("rw_stored", 32'(REG_OUT[15:8]), 32'h5C);
    step(1'b1, 1'b1, 4'd3, 8'h77);
    step(1'b1, 1'b1, 4'd14, 8'h77);
    step(1'b1, 1'b0, 4'd9, 8'h44);
    step(1'b0, 1'b1, 4'd9, 8'h00);
    step(1'b0, 1'b1, 4'd11, 8'h00);
    step(1'b0, 1'b1, 4'd12, 8'h00);
    // reset asserted during a write to reg 2: write aborted, no strobes afterwards
    @(negedge CLK);
    WrEn = 1'b1;
    RdEn = 1'b1;
    address = 4'd2;
    WrData = 8'hFF;
    #1 RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("rst_mid_reg2", 32'(REG_OUT[23:16]), 32'h21);
    chk("rst_mid_strobes", {29'h0, RdData_valid, Access_err, Upd_strobe}, 32'h0);
    @(negedge CLK);
    WrEn = 1'b0;
    RdEn = 1'b0;
    RST = 1'b1;
    step(1'b0, 1'b0, 4'd0, 8'h00);
    chk("post_rst_no_upd", 32'(Upd_strobe), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'(i), 8'h00);
      chk($sformatf("b2b_valid%0d", i), 32'(RdData_valid), 32'h1);
    end
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
